// File: rtl/surf_cout_rxcheck.sv
// COUT receive checker: shifts in ISERDES nibbles, hunts/tracks the training word,
// flags per-nibble bit errors, captures the history on request and forwards nibbles to TURF.
module surf_cout_rxcheck #(
  parameter logic [31:0] TRAIN_PATTERN = 32'hA55A6996,
  parameter int unsigned MISS_LIMIT    = 4
) (
  input  logic        sysclk_i,
  input  logic        rst_n_i,
  input  logic [3:0]  cout_nibble_i,
  input  logic        bitslip_i,
  input  logic        capture_i,
  input  logic        enable_i,
  output logic [31:0] cout_data_o,
  output logic        cout_biterr_o,
  output logic        locked_o,
  output logic [3:0]  turf_nibble_o,
  output logic        turf_valid_o
);

  localparam logic [0:0] HUNT   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;
  localparam logic [4:0] MISS_LIM = 5'(MISS_LIMIT);

  logic [0:0]  state;
  logic [31:0] sr;
  logic [3:0]  fill;
  logic [2:0]  ptr;
  logic [3:0]  miss;

  logic [31:0] nxt;
  logic [3:0]  expected;
  logic [4:0]  miss_inc;

  // nxt includes the nibble arriving this cycle, so matches and captures see it immediately
  assign nxt      = {sr[27:0], cout_nibble_i};
  assign expected = TRAIN_PATTERN[{ptr, 2'b00} +: 4];
  assign miss_inc = {1'b0, miss} + 5'd1;
  assign locked_o = (state == LOCKED);

  always_ff @(posedge sysclk_i) begin
    if (!rst_n_i) begin
      state         <= HUNT;
      sr            <= '0;
      fill          <= '0;
      ptr           <= 3'd7;
      miss          <= '0;
      cout_data_o   <= '0;
      cout_biterr_o <= 1'b1;
      turf_nibble_o <= '0;
      turf_valid_o  <= 1'b0;
    end else begin
      sr            <= nxt;
      turf_nibble_o <= enable_i ? cout_nibble_i : 4'h0;
      turf_valid_o  <= enable_i;
      if (capture_i) cout_data_o <= nxt;

      if (bitslip_i) begin
        // word alignment just changed: restart the hunt from an empty history
        state         <= HUNT;
        fill          <= '0;
        miss          <= '0;
        cout_biterr_o <= 1'b1;
      end else begin
        if (fill != 4'd8) fill <= fill + 4'd1;
        case (state)
          HUNT: begin
            cout_biterr_o <= 1'b1;
            if (fill >= 4'd7 && nxt == TRAIN_PATTERN) begin
              state <= LOCKED;
              ptr   <= 3'd7;
              miss  <= '0;
            end
          end
          default: begin
            ptr <= ptr - 3'd1;
            if (cout_nibble_i == expected) begin
              cout_biterr_o <= 1'b0;
              miss          <= '0;
            end else begin
              cout_biterr_o <= 1'b1;
              if (miss_inc == MISS_LIM) begin
                state <= HUNT;
                miss  <= '0;
              end else begin
                miss <= miss_inc[3:0];
              end
            end
          end
        endcase
      end
    end
  end

endmodule
